// File: rtl/acc_pkg.sv
// Shared types for the frame arbiter and the count_sum accumulator it feeds.
package acc_pkg;

   localparam int SEG_W = 7;

   typedef logic [1:0][SEG_W-1:0] seg_pair_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STREAM   = 2'd1,
      WAIT_RES = 2'd2,
      RESP     = 2'd3
   } arb_state_t;

endpackage

// File: rtl/acc_frame_arbiter_rr_pick.sv
// Combinational winner select for the frame arbiter.
// ACC_ARB_FIXED_PRIO_EN selects lowest-index priority; default is round-robin from i_ptr+1.
module rr_pick #(
   parameter int R  = 4,
   parameter int IW = $clog2(R)
) (
   input  logic [R-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_winner,
   output logic          o_any_req
);

   assign o_any_req = |i_req;

`ifdef ACC_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   // Scan downward so the lowest set index is the last assignment.
   always_comb begin
      o_winner = {IW{1'b0}};
      for (int k = R - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            o_winner = IW'(k);
         end else begin
            o_winner = o_winner;
         end
      end
   end
`else
   logic w_found;
   int   w_idx;

   // First requester found searching upward from ptr+1 with wrap.
   always_comb begin
      o_winner = {IW{1'b0}};
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 1; k <= R; k++) begin
         w_idx = (int'(i_ptr) + k) % R;
         if (!w_found && i_req[w_idx]) begin
            o_winner = IW'(w_idx);
            w_found  = 1'b1;
         end else begin
            w_found  = w_found;
         end
      end
   end
`endif

endmodule

// File: rtl/acc_frame_arbiter.sv
// Grants one shared frame accumulator to R AXIS requesters a whole N-beat frame at a time
// and returns the captured result tagged with the requester ID. Option: ACC_ARB_FIXED_PRIO_EN.
module acc_frame_arbiter
   import acc_pkg::*;
#(
   parameter int W = 3,
   parameter int N = 5,
   parameter int R = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [R-1:0]                 s_valid,
   output logic [R-1:0]                 s_ready,
   input  logic [R-1:0][W-1:0]          s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [W-1:0]                 m_data,
   input  logic                         acc_valid,
   output logic                         acc_ready,
   input  logic [1:0][SEG_W-1:0]        acc_data,
   output logic                         r_valid,
   input  logic                         r_ready,
   output logic [1:0][SEG_W-1:0]        r_data,
   output logic [$clog2(R)-1:0]         r_id,
   output logic [$clog2(R)-1:0]         grant_id,
   output logic                         busy
);

   localparam int IW = $clog2(R);
   localparam int CW = $clog2(N) + 1;

   arb_state_t    r_state;
   arb_state_t    w_next_state;
   logic [IW-1:0] r_grant;
   logic [IW-1:0] r_ptr;
   logic [CW-1:0] r_beat_cnt;
   seg_pair_t     r_res_data;
   logic [IW-1:0] r_res_id;

   logic [IW-1:0] w_winner;
   logic          w_any_req;
   logic          w_beat_fire;

   rr_pick #(
      .R  (R),
      .IW (IW)
   ) u_pick (
      .i_req     (s_valid),
      .i_ptr     (r_ptr),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   // Next-state decode and the combinational grant mux used during STREAM.
   always_comb begin
      w_next_state = r_state;
      m_valid      = 1'b0;
      m_data       = {W{1'b0}};
      s_ready      = {R{1'b0}};
      w_beat_fire  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_next_state = STREAM;
            end else begin
               w_next_state = IDLE;
            end
         end
         STREAM: begin
            m_valid          = s_valid[r_grant];
            m_data           = s_data[r_grant];
            s_ready[r_grant] = m_ready;
            w_beat_fire      = s_valid[r_grant] & m_ready;
            if (w_beat_fire && (r_beat_cnt == CW'(N - 1))) begin
               w_next_state = WAIT_RES;
            end else begin
               w_next_state = STREAM;
            end
         end
         WAIT_RES: begin
            if (acc_valid) begin
               w_next_state = RESP;
            end else begin
               w_next_state = WAIT_RES;
            end
         end
         RESP: begin
            if (r_ready) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = RESP;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, grant, beat counter, rotation pointer and captured result.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_grant    <= {IW{1'b0}};
         r_ptr      <= IW'(R - 1);
         r_beat_cnt <= {CW{1'b0}};
         r_res_data <= {(2 * SEG_W){1'b0}};
         r_res_id   <= {IW{1'b0}};
      end else begin
         r_state <= w_next_state;
         if ((r_state == IDLE) && w_any_req) begin
            r_grant    <= w_winner;
            r_beat_cnt <= {CW{1'b0}};
         end else if (w_beat_fire) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
         end else begin
            r_beat_cnt <= r_beat_cnt;
         end
         if ((r_state == WAIT_RES) && acc_valid) begin
            r_res_data <= acc_data;
            r_res_id   <= r_grant;
         end else begin
            r_res_data <= r_res_data;
         end
         if ((r_state == RESP) && r_ready) begin
            r_ptr <= r_grant;
         end else begin
            r_ptr <= r_ptr;
         end
      end
   end

   assign acc_ready = (r_state == WAIT_RES);
   assign r_valid   = (r_state == RESP);
   assign busy      = (r_state != IDLE);
   assign r_data    = r_res_data;
   assign r_id      = r_res_id;
   assign grant_id  = r_grant;

endmodule

// File: tb/tb_acc_frame_arbiter.sv
// Self-checking bench for acc_frame_arbiter: directed scenarios plus randomized frames
// checked against a rule-level model of grant selection and frame length.
module tb_acc_frame_arbiter;

   localparam int W  = 3;
   localparam int N  = 5;
   localparam int R  = 4;
   localparam int IW = $clog2(R);

   logic                 clk;
   logic                 rstn;
   logic [R-1:0]         s_valid;
   logic [R-1:0]         s_ready;
   logic [R-1:0][W-1:0]  s_data;
   logic                 m_valid;
   logic                 m_ready;
   logic [W-1:0]         m_data;
   logic                 acc_valid;
   logic                 acc_ready;
   logic [1:0][6:0]      acc_data;
   logic                 r_valid;
   logic                 r_ready;
   logic [1:0][6:0]      r_data;
   logic [IW-1:0]        r_id;
   logic [IW-1:0]        grant_id;
   logic                 busy;

   int checks;
   int failures;
   int exp_ptr;

   acc_frame_arbiter #(.W(W), .N(N), .R(R)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .acc_data  (acc_data),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .r_data    (r_data),
      .r_id      (r_id),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_pick(logic [R-1:0] req, int ptr);
`ifdef ACC_ARB_FIXED_PRIO_EN
      for (int i = 0; i < R; i++) if (req[i]) return i;
`else
      for (int k = 1; k <= R; k++) if (req[(ptr + k) % R]) return (ptr + k) % R;
`endif
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; s_valid = '0; m_ready = 1'b0; acc_valid = 1'b0; r_ready = 1'b0;
      tick();
      rstn = 1'b1;
      exp_ptr = R - 1;
   endtask

   task automatic finish_frame(input logic [6:0] tens, input logic [6:0] ones);
      acc_valid = 1'b1; acc_data[1] = tens; acc_data[0] = ones;
      tick();
      acc_valid = 1'b0; r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; s_valid = 4'hF; m_ready = 1'b1; acc_valid = 1'b1; r_ready = 1'b1;
      acc_data[1] = 7'd9; acc_data[0] = 7'd9;
      tick();
      checks++;
      if ({s_ready, m_valid, m_data, acc_ready, r_valid, r_data, r_id, grant_id, busy} !== 29'd0) begin
         failures++;
         $display("FAIL reset_outputs got s_ready=%b m_valid=%b m_data=%0d acc_ready=%b r_valid=%b r_data=%h r_id=%0d grant=%0d busy=%b want all 0",
                  s_ready, m_valid, m_data, acc_ready, r_valid, r_data, r_id, grant_id, busy);
      end
      rstn = 1'b1; s_valid = '0; r_ready = 1'b0;
      tick();
      checks++;
      if ({acc_ready, r_valid, r_data, busy} !== 17'd0) begin
         failures++;
         $display("FAIL idle_acc_ignored got acc_ready=%b r_valid=%b r_data=%h busy=%b want 0", acc_ready, r_valid, r_data, busy);
      end
      acc_valid = 1'b0;
      exp_ptr = R - 1;
   endtask

   task automatic test_single_stream();
      int vals[5] = '{3, 4, 5, 2, 6};
      s_valid = 4'b0010; m_ready = 1'b1; s_data[1] = W'(vals[0]);
      tick();
      checks++;
      if (grant_id !== 2'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_grant got grant=%0d busy=%b want 1 1", grant_id, busy);
      end
      for (int b = 0; b < 5; b++) begin
         s_data[1] = W'(vals[b]);
         s_data[0] = W'($urandom_range(0, 7)); s_data[2] = W'($urandom_range(0, 7));
         #1;
         checks++;
         if (m_valid !== 1'b1 || m_data !== W'(vals[b]) || s_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_beat%0d got m_valid=%b m_data=%0d s_ready=%b want 1 %0d 0010", b, m_valid, m_data, s_ready, vals[b]);
         end
         tick();
      end
      s_valid = '0;
      #1;
      checks++;
      if (acc_ready !== 1'b1 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_wait got acc_ready=%b m_valid=%b want 1 0", acc_ready, m_valid);
      end
      acc_valid = 1'b1; acc_data[1] = 7'd2; acc_data[0] = 7'd0;
      tick();
      acc_valid = 1'b0;
      checks++;
      if (r_valid !== 1'b1 || r_data[1] !== 7'd2 || r_data[0] !== 7'd0 || r_id !== 2'd1 || acc_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_result got r_valid=%b r_data=%0d,%0d r_id=%0d acc_ready=%b want 1 2,0 1 0",
                  r_valid, r_data[1], r_data[0], r_id, acc_ready);
      end
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || r_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_release got busy=%b r_valid=%b want 0 0", busy, r_valid);
      end
      exp_ptr = 1;
   endtask

   task automatic test_fairness();
      int exp;
      logic [R-1:0] oh;
      do_reset();
      s_valid = 4'hF; m_ready = 1'b1;
      for (int f = 0; f < 5; f++) begin
         exp = model_pick(s_valid, exp_ptr);
         oh = R'(1) << exp;
         tick();
         checks++;
         if (grant_id !== IW'(exp)) begin
            failures++;
            $display("FAIL fair_grant%0d got %0d want %0d", f, grant_id, exp);
         end
         for (int b = 0; b < N; b++) begin
            s_data[exp] = W'($urandom_range(0, 7));
            #1;
            checks++;
            if (m_valid !== 1'b1 || s_ready !== oh || acc_ready !== 1'b0 || m_data !== s_data[exp]) begin
               failures++;
               $display("FAIL fair_beat f%0d b%0d got m_valid=%b s_ready=%b acc_ready=%b m_data=%0d want 1 %b 0 %0d",
                        f, b, m_valid, s_ready, acc_ready, m_data, oh, s_data[exp]);
            end
            tick();
         end
         checks++;
         if (acc_ready !== 1'b1) begin
            failures++;
            $display("FAIL fair_len%0d got acc_ready=%b want 1", f, acc_ready);
         end
         finish_frame(7'd1, 7'd2);
         exp_ptr = exp;
      end
      s_valid = '0;
   endtask

   task automatic test_stall();
      do_reset();
      s_valid = 4'b0100; m_ready = 1'b1;
      tick();
      for (int b = 0; b < 2; b++) tick();
      for (int c = 0; c < 3; c++) begin
         s_valid = 4'b1011;
         #1;
         checks++;
         if (m_valid !== 1'b0 || grant_id !== 2'd2 || acc_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d got m_valid=%b grant=%0d acc_ready=%b want 0 2 0", c, m_valid, grant_id, acc_ready);
         end
         tick();
      end
      s_valid = 4'b0100;
      for (int b = 0; b < 3; b++) begin
         #1;
         checks++;
         if (m_valid !== 1'b1 || acc_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume%0d got m_valid=%b acc_ready=%b want 1 0", b, m_valid, acc_ready);
         end
         tick();
      end
      checks++;
      if (acc_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_len got acc_ready=%b want 1", acc_ready);
      end
      s_valid = '0;
      finish_frame(7'd0, 7'd0);
   endtask

   task automatic test_backpressure();
      logic [1:0][6:0] res;
      do_reset();
      s_valid = 4'b0001; m_ready = 1'b1;
      tick();
      for (int b = 0; b < 2; b++) tick();
      m_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (s_ready !== 4'b0000 || m_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_mready%0d got s_ready=%b m_valid=%b want 0000 1", c, s_ready, m_valid);
         end
         tick();
      end
      m_ready = 1'b1;
      for (int b = 0; b < 3; b++) tick();
      checks++;
      if (acc_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_len got acc_ready=%b want 1", acc_ready);
      end
      s_valid = '0;
      res[1] = 7'($urandom_range(0, 127)); res[0] = 7'($urandom_range(0, 127));
      acc_valid = 1'b1; acc_data = res;
      tick();
      for (int c = 0; c < 4; c++) begin
         acc_data[1] = ~res[1]; acc_data[0] = ~res[0]; s_valid = 4'hF;
         #1;
         checks++;
         if (r_valid !== 1'b1 || r_data !== res || r_id !== 2'd0) begin
            failures++;
            $display("FAIL bp_resp_hold%0d got r_valid=%b r_data=%h r_id=%0d want 1 %h 0", c, r_valid, r_data, r_id, res);
         end
         tick();
      end
      acc_valid = 1'b0; s_valid = '0; r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      s_valid = 4'b0101; m_ready = 1'b1;
      tick();
      for (int b = 0; b < 3; b++) tick();
      rstn = 1'b0; acc_valid = 1'b1;
      tick();
      checks++;
      if ({s_ready, m_valid, m_data, acc_ready, r_valid, r_data, r_id, grant_id, busy} !== 29'd0) begin
         failures++;
         $display("FAIL midreset_outputs got s_ready=%b m_valid=%b acc_ready=%b r_valid=%b grant=%0d busy=%b want all 0",
                  s_ready, m_valid, acc_ready, r_valid, grant_id, busy);
      end
      rstn = 1'b1; acc_valid = 1'b0; exp_ptr = R - 1;
      tick();
      checks++;
      if (grant_id !== 2'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midreset_grant got grant=%0d busy=%b want 0 1", grant_id, busy);
      end
      for (int b = 0; b < N - 1; b++) tick();
      checks++;
      if (acc_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_fresh got acc_ready=%b want 0", acc_ready);
      end
      tick();
      checks++;
      if (acc_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_len got acc_ready=%b want 1", acc_ready);
      end
      s_valid = '0;
      finish_frame(7'd3, 7'd3);
   endtask

   task automatic test_two_requesters();
      int exp;
      do_reset();
      s_valid = 4'b1001; m_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         exp = model_pick(s_valid, exp_ptr);
         tick();
         checks++;
         if (grant_id !== IW'(exp)) begin
            failures++;
            $display("FAIL two_req_grant%0d got %0d want %0d", f, grant_id, exp);
         end
         repeat (N) tick();
         finish_frame(7'd0, 7'd1);
         exp_ptr = exp;
      end
      s_valid = '0;
   endtask

   task automatic test_random();
      int exp, beats, budget, dly;
      logic [R-1:0] req, oh;
      logic [1:0][6:0] res;
      do_reset();
      for (int f = 0; f < 40; f++) begin
         req = R'($urandom_range(0, 15));
         s_valid = req; m_ready = 1'($urandom_range(0, 1)); acc_valid = 1'($urandom_range(0, 1));
         acc_data[0] = 7'($urandom_range(0, 127)); acc_data[1] = 7'($urandom_range(0, 127));
         if (req == '0) begin
            tick();
            checks++;
            if (busy !== 1'b0 || acc_ready !== 1'b0) begin
               failures++;
               $display("FAIL rnd_idle%0d got busy=%b acc_ready=%b want 0 0", f, busy, acc_ready);
            end
            req = R'($urandom_range(1, 15));
            s_valid = req;
         end
         exp = model_pick(req, exp_ptr);
         oh = R'(1) << exp;
         tick();
         checks++;
         if (grant_id !== IW'(exp) || busy !== 1'b1) begin
            failures++;
            $display("FAIL rnd_grant%0d got grant=%0d busy=%b want %0d 1 (req=%b)", f, grant_id, busy, exp, req);
         end
         beats = 0; budget = 0;
         while (beats < N && budget < 200) begin
            s_valid = R'($urandom_range(0, 15));
            s_valid[exp] = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < R; i++) s_data[i] = W'($urandom_range(0, 7));
            acc_valid = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (m_valid !== s_valid[exp] || s_ready !== (m_ready ? oh : 4'b0000) || acc_ready !== 1'b0 ||
                (s_valid[exp] && m_data !== s_data[exp])) begin
               failures++;
               $display("FAIL rnd_stream f%0d beat%0d got m_valid=%b m_data=%0d s_ready=%b acc_ready=%b want %b %0d %b 0",
                        f, beats, m_valid, m_data, s_ready, acc_ready, s_valid[exp], s_data[exp], (m_ready ? oh : 4'b0000));
            end
            if (s_valid[exp] && m_ready) beats++;
            budget++;
            tick();
         end
         if (budget >= 200) begin
            checks++; failures++;
            $display("FAIL rnd_timeout f%0d got %0d beats want %0d", f, beats, N);
         end
         acc_valid = 1'b0;
         dly = $urandom_range(0, 3);
         for (int c = 0; c < dly; c++) begin
            s_valid = R'($urandom_range(0, 15));
            #1;
            checks++;
            if (acc_ready !== 1'b1 || m_valid !== 1'b0 || s_ready !== 4'b0000) begin
               failures++;
               $display("FAIL rnd_wait f%0d got acc_ready=%b m_valid=%b s_ready=%b want 1 0 0000", f, acc_ready, m_valid, s_ready);
            end
            tick();
         end
         res[0] = 7'($urandom_range(0, 127)); res[1] = 7'($urandom_range(0, 127));
         acc_valid = 1'b1; acc_data = res;
         #1;
         checks++;
         if (acc_ready !== 1'b1) begin
            failures++;
            $display("FAIL rnd_accready f%0d got %b want 1", f, acc_ready);
         end
         tick();
         dly = $urandom_range(0, 3);
         for (int c = 0; c < dly; c++) begin
            acc_valid = 1'($urandom_range(0, 1));
            acc_data[0] = 7'($urandom_range(0, 127)); acc_data[1] = 7'($urandom_range(0, 127));
            s_valid = R'($urandom_range(0, 15));
            #1;
            checks++;
            if (r_valid !== 1'b1 || r_data !== res || r_id !== IW'(exp) || grant_id !== IW'(exp)) begin
               failures++;
               $display("FAIL rnd_resp f%0d got r_valid=%b r_data=%h r_id=%0d grant=%0d want 1 %h %0d %0d",
                        f, r_valid, r_data, r_id, grant_id, res, exp, exp);
            end
            tick();
         end
         acc_valid = 1'b0; r_ready = 1'b1;
         #1;
         checks++;
         if (r_valid !== 1'b1 || r_data !== res || r_id !== IW'(exp)) begin
            failures++;
            $display("FAIL rnd_result f%0d got r_valid=%b r_data=%h r_id=%0d want 1 %h %0d", f, r_valid, r_data, r_id, res, exp);
         end
         tick();
         r_ready = 1'b0;
         exp_ptr = exp;
      end
      s_valid = '0;
   endtask

   initial begin
      checks = 0; failures = 0; exp_ptr = R - 1;
      rstn = 1'b0; s_valid = '0; s_data = '0; m_ready = 1'b0;
      acc_valid = 1'b0; acc_data = '0; r_ready = 1'b0;
      test_reset();
      test_single_stream();
      test_fairness();
      test_stall();
      test_backpressure();
      test_reset_mid_frame();
      test_two_requesters();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
